// File: rtl/async_handshake_tx_if.sv
// Local-side and peer-side signals of the 4-phase bundled-data transmitter.
// The master modport is the transmitter; the slave modport is whoever feeds and acks it.
interface async_handshake_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             req_out;
  logic [WIDTH-1:0] data_out;
  logic             ack_async;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             err_clr;

  modport master (
    input  in_valid, in_data, ack_async, err_clr,
    output in_ready, req_out, data_out, busy, done, timeout_err
  );

  modport slave (
    output in_valid, in_data, ack_async, err_clr,
    input  in_ready, req_out, data_out, busy, done, timeout_err
  );
endinterface

// File: rtl/async_handshake_tx.sv
// 4-phase req/ack transmitter: holds bundled data for SETUP_CYC cycles, raises req,
// waits for the synchronized peer ack to rise then fall, with a per-phase timeout.
module async_handshake_tx #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] INIVAL      = '0,
  parameter int               SETUP_CYC   = 2,
  parameter int               TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  async_handshake_tx_if.master bus
);

  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC + 1) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SW-1:0] SINIT = SW'(SETUP_CYC);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, REQ_LO, ERR} state_t;

  state_t           state, state_nxt;
  logic             ack_p0, ack_p1;
  logic             ack_sync;
  logic             in_ready;
  logic             to_hit;
  logic             load;
  logic             req_q, req_nxt;
  logic             done_q, done_nxt;
  logic             terr_q, terr_nxt;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    scnt, scnt_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;

  // ack_async crosses into clk here; nothing downstream looks at ack_p0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_p0 <= 1'b0;
      ack_p1 <= 1'b0;
    end else begin
      ack_p0 <= bus.ack_async;
      ack_p1 <= ack_p0;
    end
  end

  assign ack_sync = ack_p1;
  assign in_ready = (state == IDLE) && !ack_sync;
  assign to_hit   = (TIMEOUT_CYC != 0) && (tcnt == TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      done_q <= 1'b0;
      terr_q <= 1'b0;
      data_q <= INIVAL;
      scnt   <= '0;
      tcnt   <= '0;
    end else begin
      state  <= state_nxt;
      req_q  <= req_nxt;
      done_q <= done_nxt;
      terr_q <= terr_nxt;
      scnt   <= scnt_nxt;
      tcnt   <= tcnt_nxt;
      if (load) data_q <= bus.in_data;
    end
  end

  // An exit condition is tested before the timeout so it wins on a tie
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid && in_ready) state_nxt = SETUP;
      SETUP:   if (scnt == '0) state_nxt = REQ_HI;
      REQ_HI:  if (ack_sync) state_nxt = REQ_LO;
               else if (to_hit) state_nxt = ERR;
      REQ_LO:  if (!ack_sync) state_nxt = IDLE;
               else if (to_hit) state_nxt = ERR;
      ERR:     if (bus.err_clr && !ack_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and counters follow from the transition being taken
  always_comb begin
    req_nxt  = (state_nxt == REQ_HI);
    done_nxt = (state == REQ_LO) && (state_nxt == IDLE);
    terr_nxt = (state_nxt == ERR);
    load     = (state == IDLE) && (state_nxt == SETUP);

    scnt_nxt = scnt;
    if (load)
      scnt_nxt = SINIT;
    else if ((state == SETUP) && (scnt != '0))
      scnt_nxt = scnt - SW'(1);

    tcnt_nxt = tcnt;
    if (state_nxt != state)
      tcnt_nxt = '0;
    else if ((state == REQ_HI) || (state == REQ_LO))
      tcnt_nxt = tcnt + TW'(1);
  end

  assign bus.in_ready    = in_ready;
  assign bus.req_out     = req_q;
  assign bus.data_out    = data_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_async_handshake_tx.sv
// Directed bench for async_handshake_tx: a scoreboard queue holds accepted words and a
// negedge monitor checks each word the peer sees at req rise, plus done pulse shape.
module tb_async_handshake_tx;

  logic clk;
  logic rst;
  logic ack_man;
  logic ack_auto;
  logic req_seen;
  logic peer_auto;

  int checks   = 0;
  int failures = 0;
  int req_rises = 0;
  int done_cnt  = 0;

  logic [7:0] exp_q[$];

  async_handshake_tx_if #(.WIDTH(8)) bus ();

  async_handshake_tx #(
    .WIDTH(8), .INIVAL(8'h00), .SETUP_CYC(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.ack_async = peer_auto ? ack_auto : ack_man;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input int max);
    int n = 0;
    while (!bus.in_ready && n < max) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_ready actual=expired required=in_ready");
    end
  endtask

  task automatic wait_done(input int target, input int max);
    int n = 0;
    while (done_cnt < target && n < max) begin
      tick();
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual=%0d required=%0d", done_cnt, target);
    end
  endtask

  // Peer model: ack follows req with one cycle of lag
  initial begin
    ack_auto = 1'b0;
    req_seen = 1'b0;
    forever begin
      @(negedge clk);
      ack_auto = peer_auto ? req_seen : 1'b0;
      req_seen = peer_auto ? bus.req_out : 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each req rise and watches data and done
  initial begin
    logic       req_prev;
    logic       done_prev;
    logic       have_held;
    logic [7:0] held;
    logic [7:0] w;
    req_prev  = 1'b0;
    done_prev = 1'b0;
    have_held = 1'b0;
    held      = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev  = 1'b0;
        done_prev = 1'b0;
        have_held = 1'b0;
      end else begin
        if (bus.req_out && !req_prev) begin
          req_rises++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL peer_data actual=%0h required=no_request", bus.data_out);
          end else begin
            w = exp_q.pop_front();
            chk("peer_data", 32'(bus.data_out), 32'(w));
          end
          held      = bus.data_out;
          have_held = 1'b1;
        end else if ((bus.req_out || bus.ack_async) && have_held) begin
          chk("data_stable", 32'(bus.data_out), 32'(held));
        end
        if (bus.done) begin
          done_cnt++;
          chk("done_in_ready", 32'(bus.in_ready), 1);
          chk("done_width", 32'(done_prev), 0);
        end
        req_prev  = bus.req_out;
        done_prev = bus.done;
      end
    end
  end

  initial begin
    int base_req;
    int base_done;
    int dc;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.err_clr  = 1'b0;
    ack_man      = 1'b0;
    peer_auto    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.req_out), 0);
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(bus.in_ready), 1);

    // Single transfer with exact edge timing
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    bus.in_valid = 1'b0;
    chk("t2_data_e0", 32'(bus.data_out), 'hA5);
    chk("t2_req_e0", 32'(bus.req_out), 0);
    tick();
    chk("t2_req_e1", 32'(bus.req_out), 0);
    tick();
    chk("t2_req_e2", 32'(bus.req_out), 0);
    tick();
    chk("t2_req_e3", 32'(bus.req_out), 1);
    tick();
    ack_man = 1'b1;
    tick();
    chk("t2_req_a0", 32'(bus.req_out), 1);
    tick();
    chk("t2_req_a1", 32'(bus.req_out), 1);
    tick();
    chk("t2_req_a2", 32'(bus.req_out), 0);
    ack_man = 1'b0;
    tick();
    chk("t2_done_f0", 32'(bus.done), 0);
    tick();
    chk("t2_done_f1", 32'(bus.done), 0);
    chk("t2_ready_f1", 32'(bus.in_ready), 0);
    tick();
    chk("t2_done_f2", 32'(bus.done), 1);
    chk("t2_ready_f2", 32'(bus.in_ready), 1);
    tick();
    chk("t2_done_f3", 32'(bus.done), 0);

    // Back-to-back words with the automatic peer
    base_req  = req_rises;
    base_done = done_cnt;
    peer_auto = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 8'(i);
      wait_ready(64);
      exp_q.push_back(8'(i));
      tick();
      chk("t3_accept", 32'(bus.data_out), 32'(i));
    end
    bus.in_valid = 1'b0;
    wait_done(base_done + 3, 200);
    chk("t3_req_pulses", 32'(req_rises - base_req), 3);
    chk("t3_done_pulses", 32'(done_cnt - base_done), 3);
    repeat (2) tick();
    peer_auto = 1'b0;
    tick();

    // Timeout waiting for ack rise
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    exp_q.push_back(8'h5A);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("t4_req_up", 32'(bus.req_out), 1);
    repeat (15) tick();
    chk("t4_req_pre", 32'(bus.req_out), 1);
    chk("t4_terr_pre", 32'(bus.timeout_err), 0);
    tick();
    chk("t4_req_err", 32'(bus.req_out), 0);
    chk("t4_terr_err", 32'(bus.timeout_err), 1);
    chk("t4_ready_err", 32'(bus.in_ready), 0);
    chk("t4_busy_err", 32'(bus.busy), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (2) tick();
    chk("t4_ignore_data", 32'(bus.data_out), 'h5A);
    chk("t4_ignore_busy", 32'(bus.busy), 1);
    bus.in_valid = 1'b0;
    dc = done_cnt;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("t4_clr_terr", 32'(bus.timeout_err), 0);
    chk("t4_clr_ready", 32'(bus.in_ready), 1);
    chk("t4_clr_busy", 32'(bus.busy), 0);
    tick();
    chk("t4_no_done", 32'(done_cnt), 32'(dc));

    // Timeout waiting for ack fall
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    exp_q.push_back(8'h77);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("t4b_req_up", 32'(bus.req_out), 1);
    ack_man = 1'b1;
    repeat (3) tick();
    chk("t4b_req_lo", 32'(bus.req_out), 0);
    chk("t4b_busy_lo", 32'(bus.busy), 1);
    repeat (15) tick();
    chk("t4b_terr_pre", 32'(bus.timeout_err), 0);
    tick();
    chk("t4b_terr_err", 32'(bus.timeout_err), 1);
    chk("t4b_ready_err", 32'(bus.in_ready), 0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("t4b_clr_blocked", 32'(bus.timeout_err), 1);
    ack_man = 1'b0;
    repeat (2) tick();
    dc = done_cnt;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("t4b_clr_terr", 32'(bus.timeout_err), 0);
    chk("t4b_clr_ready", 32'(bus.in_ready), 1);
    tick();
    chk("t4b_no_done", 32'(done_cnt), 32'(dc));

    // Ack held high while idle
    ack_man = 1'b1;
    tick();
    chk("t5_ready_a0", 32'(bus.in_ready), 1);
    tick();
    chk("t5_ready_a1", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    tick();
    chk("t5_not_busy", 32'(bus.busy), 0);
    chk("t5_data_kept", 32'(bus.data_out), 'h77);
    bus.in_valid = 1'b0;
    ack_man = 1'b0;
    tick();
    chk("t5_ready_f0", 32'(bus.in_ready), 0);
    tick();
    chk("t5_ready_f1", 32'(bus.in_ready), 1);

    // Asynchronous reset mid-handshake, then a clean transfer
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    exp_q.push_back(8'hC3);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("t6_req_up", 32'(bus.req_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_req", 32'(bus.req_out), 0);
    chk("t6_async_data", 32'(bus.data_out), 0);
    chk("t6_async_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    dc = done_cnt;
    peer_auto = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    wait_ready(16);
    exp_q.push_back(8'h3C);
    tick();
    bus.in_valid = 1'b0;
    chk("t6_data", 32'(bus.data_out), 'h3C);
    wait_done(dc + 1, 100);
    repeat (2) tick();
    peer_auto = 1'b0;

    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("total_req", 32'(req_rises), 8);
    chk("total_done", 32'(done_cnt), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_handshake_tx.md
Name: async_handshake_tx

Overview:
Transmit side of a 4-phase (req/ack, bundled-data) handshake to a peer running on an unrelated clock or on no clock. The block accepts words from the local clk domain over a valid/ready interface. It drives data_out and req_out, and waits for the peer's asynchronous ack through an internal 2-stage synchronizer. It is the output-direction counterpart of the board input synchronizers and sits between core-side peripherals and board-level async devices.

Parameters:
WIDTH, 8, data word width
INIVAL, {WIDTH{1'b0}}, data_out value at reset
SETUP_CYC, 2, number of clk cycles data_out is held stable before req_out rises (0 allowed)
TIMEOUT_CYC, 1024, number of cycles allowed in each ack-wait phase before error; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  local word available
in_data  in  WIDTH  local word
in_ready  out  1  block can accept a word (combinational)
req_out  out  1  request to peer, registered
data_out  out  WIDTH  bundled data to peer, registered
ack_async  in  1  peer acknowledge, asynchronous to clk
busy  out  1  handshake in progress (state != IDLE)
done  out  1  one-cycle pulse: handshake completed
timeout_err  out  1  sticky timeout flag
err_clr  in  1  clears the error and leaves the ERR state

Behaviour:
- Reset (asynchronous, effective immediately, including mid-handshake): state=IDLE, req_out=0, data_out=INIVAL, done=0, timeout_err=0, both synchronizer flops=0, all counters=0.
- ack_sync is the output of 2 flops on ack_async. A change on ack_async before edge A is seen by the FSM at edge A+2.
- in_ready = (state==IDLE) && !ack_sync. in_data is ignored when in_ready=0.
- IDLE: on an edge with in_valid && in_ready: data_out<=in_data, scnt<=SETUP_CYC, state->SETUP.
- SETUP: if scnt==0, req_out<=1 and state->REQ_HI; otherwise scnt decrements.
  - req_out therefore rises at accept edge + SETUP_CYC + 1.
- REQ_HI: when ack_sync==1, req_out<=0 and state->REQ_LO.
- REQ_LO: when ack_sync==0, state->IDLE and done<=1 for exactly one cycle.
  - done and in_ready are both high in that cycle, so back-to-back transfers are possible.
- data_out changes only on an accept edge. It holds from accept until the next accept, including through ERR.
- Timeout:
  - tcnt clears on entry to REQ_HI and on entry to REQ_LO, and increments each cycle in those states.
  - If the exit condition is false on the edge where tcnt==TIMEOUT_CYC-1, then: state->ERR, req_out<=0, timeout_err<=1.
  - If the exit condition and the timeout occur on the same edge, the exit condition wins.
  - With TIMEOUT_CYC=0 the block never times out.
- ERR: in_ready=0 and busy=1. On err_clr==1 with ack_sync==0: timeout_err<=0 and state->IDLE, with no done pulse. err_clr has no effect in any other state.
- ack_sync rising while in IDLE or SETUP is ignored, apart from blocking in_ready. ack_sync falling in REQ_HI has no effect.
- req_out is driven straight from a flop (glitch-free). data_out never changes while req_out=1 or while the peer ack is pending.

Test Plan:
1. Reset: assert rst for 2 cycles with WIDTH=8, INIVAL=8'h00. Require req_out=0, data_out=8'h00, in_ready=1, busy=0, done=0, timeout_err=0. Assert rst asynchronously between edges and check the outputs change before the next edge.
2. Single transfer (SETUP_CYC=2): in_valid=1 with 8'hA5 accepted at edge E0. Require data_out=8'hA5 after E0 and req_out=1 after E3. The peer model raises ack 1 cycle after req; req_out must fall exactly 2 edges after the ack rise. The peer drops ack; done must pulse high for 1 cycle 2 edges after the ack fall, and in_ready=1 in that same cycle.
3. Back-to-back: hold in_valid=1 with words 8'h01, 8'h02, 8'h03 presented in turn. Require exactly 3 req_out pulses and 3 done pulses. The peer samples 01, 02, 03 in order, and data_out is stable whenever req_out=1 or ack is high.
4. Timeout (TIMEOUT_CYC=16): the peer never acks. Require ERR exactly 16 cycles after req_out rises: req_out=0, timeout_err=1, in_ready=0, and in_valid is ignored. Pulse err_clr with ack low; require timeout_err=0, in_ready=1, and no done pulse. Repeat the scenario with ack stuck high in REQ_LO.
5. Ack held high while idle: in_ready=0 and in_valid is not accepted. Lower ack; in_ready must return to 1 exactly 2 edges later.
6. Reset mid-handshake: assert rst while req_out=1. Require req_out=0 and data_out=INIVAL immediately. After release, a new transfer of 8'h3C completes normally.
